// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board geometry, render states and cell colour type
package tetris_pkg;
  localparam int BOARD_W     = 12;
  localparam int BOARD_H     = 19;
  localparam int CELL_PX     = 16;
  localparam int BOARD_CELLS = BOARD_W * BOARD_H;

  typedef logic [3:0] cell_color_t;

  typedef enum logic [2:0] {
    CLEAR, IDLE, LOCK0, LOCK1, LOCK2, LOCK3, LOAD
  } render_state_t;

  function automatic logic [9:0] cell_addr(input logic [9:0] row, input logic [9:0] col,
                                           input logic [9:0] width);
    return row * width + col;
  endfunction
endpackage

// File: rtl/board_ram.sv
// rtl/board_ram.sv - cell colour RAM, one write port and one registered read port
// Read-first: a read and write to the same address in one cycle returns the old entry.
module board_ram #(
  parameter int DEPTH = 228,
  parameter int AW    = 8,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - locks the previous falling piece into the board and renders pixels
// Pixel path is a fixed two-stage pipeline independent of the lock/clear state machine.
module board_renderer #(
  parameter int         CELL_PX  = tetris_pkg::CELL_PX,
  parameter logic [9:0] BOARD_X0 = 10'd240,
  parameter logic [9:0] BOARD_Y0 = 10'd48,
  parameter int         BOARD_W  = tetris_pkg::BOARD_W,
  parameter int         BOARD_H  = tetris_pkg::BOARD_H
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic [5:0] blockX1Pos,
  input  logic [5:0] blockX2Pos,
  input  logic [5:0] blockX3Pos,
  input  logic [5:0] blockX4Pos,
  input  logic [6:0] blockY1Pos,
  input  logic [6:0] blockY2Pos,
  input  logic [6:0] blockY3Pos,
  input  logic [6:0] blockY4Pos,
  input  logic [3:0] blockColor,
  output logic [3:0] pixel_index,
  output logic       busy
);
  import tetris_pkg::*;

  localparam int              CELLS     = BOARD_W * BOARD_H;
  localparam int              AW        = $clog2(CELLS);
  localparam int              SH        = $clog2(CELL_PX);
  localparam logic [9:0]      W10       = 10'(BOARD_W);
  localparam logic [9:0]      H10       = 10'(BOARD_H);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(CELLS - 1);

  render_state_t   state, state_nxt;
  logic [AW-1:0]   clr_addr;
  logic [3:0][5:0] in_x, pend_x, shad_x;
  logic [3:0][6:0] in_y, pend_y, shad_y;
  cell_color_t     pend_color, shad_color;

  logic [1:0]      lock_sel;
  logic [9:0]      lock_col, lock_row;
  logic            lock_ok;
  logic [AW-1:0]   lock_addr;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr, rd_addr;
  cell_color_t     ram_wdata, ram_rdata;

  logic [9:0]      dx, dy, col, row;
  logic            in_board, hit;
  logic            s1_show, s1_hit;
  cell_color_t     s1_color;

  assign in_x = {blockX4Pos, blockX3Pos, blockX2Pos, blockX1Pos};
  assign in_y = {blockY4Pos, blockY3Pos, blockY2Pos, blockY1Pos};

  assign busy = (state == CLEAR) || (state == LOCK0) || (state == LOCK1) ||
                (state == LOCK2) || (state == LOCK3);

  always_comb begin
    lock_sel = 2'd0;
    case (state)
      LOCK1:   lock_sel = 2'd1;
      LOCK2:   lock_sel = 2'd2;
      LOCK3:   lock_sel = 2'd3;
      default: lock_sel = 2'd0;
    endcase
  end

  // Off-board shadow cells (e.g. a piece poking past the bottom) must never alias a real cell.
  assign lock_col  = {4'b0, shad_x[lock_sel]};
  assign lock_row  = {3'b0, shad_y[lock_sel]};
  assign lock_ok   = (lock_col < W10) && (lock_row < H10);
  assign lock_addr = AW'(cell_addr(lock_row, lock_col, W10));

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_waddr = clr_addr;
    ram_wdata = '0;
    case (state)
      CLEAR: begin
        ram_we = 1'b1;
        if (clr_addr == LAST_ADDR) state_nxt = IDLE;
      end
      IDLE:
        if (frame_start) state_nxt = (blockColor != shad_color) ? LOCK0 : LOAD;
      LOCK0, LOCK1, LOCK2, LOCK3: begin
        ram_we    = lock_ok;
        ram_waddr = lock_addr;
        ram_wdata = shad_color;
        case (state)
          LOCK0:   state_nxt = LOCK1;
          LOCK1:   state_nxt = LOCK2;
          LOCK2:   state_nxt = LOCK3;
          default: state_nxt = LOAD;
        endcase
      end
      LOAD:    state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_color <= '0;
      shad_x     <= '0;
      shad_y     <= '0;
      shad_color <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_addr <= clr_addr + AW'(1);
      if (state == IDLE && frame_start) begin
        pend_x     <= in_x;
        pend_y     <= in_y;
        pend_color <= blockColor;
      end
      if (state == LOAD) begin
        shad_x     <= pend_x;
        shad_y     <= pend_y;
        shad_color <= pend_color;
      end
    end
  end

  // Unsigned wrap of the subtraction is caught by the explicit >= origin tests.
  assign dx       = DrawX - BOARD_X0;
  assign dy       = DrawY - BOARD_Y0;
  assign col      = dx >> SH;
  assign row      = dy >> SH;
  assign in_board = (DrawX >= BOARD_X0) && (DrawY >= BOARD_Y0) && (col < W10) && (row < H10);
  assign rd_addr  = in_board ? AW'(cell_addr(row, col, W10)) : '0;

  always_comb begin
    hit = 1'b0;
    for (int b = 0; b < 4; b++)
      if (({4'b0, shad_x[b]} == col) && ({3'b0, shad_y[b]} == row)) hit = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_show     <= 1'b0;
      s1_hit      <= 1'b0;
      s1_color    <= '0;
      pixel_index <= '0;
    end else begin
      s1_show  <= blank && in_board && (state != CLEAR);
      s1_hit   <= hit;
      s1_color <= shad_color;
      if (!s1_show)    pixel_index <= '0;
      else if (s1_hit) pixel_index <= s1_color;
      else             pixel_index <= ram_rdata;
    end
  end

  board_ram #(.DEPTH(CELLS), .AW(AW), .DW(4)) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_board_renderer.sv
// tb/tb_board_renderer.sv - randomized scoreboard bench for board_renderer
module tb_board_renderer;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_start = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       blank = 1'b0;
  logic [5:0] blockX1Pos = '0, blockX2Pos = '0, blockX3Pos = '0, blockX4Pos = '0;
  logic [6:0] blockY1Pos = '0, blockY2Pos = '0, blockY3Pos = '0, blockY4Pos = '0;
  logic [3:0] blockColor = '0;
  logic [3:0] pixel_index;
  logic       busy;

  board_renderer dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .blockX1Pos(blockX1Pos), .blockX2Pos(blockX2Pos), .blockX3Pos(blockX3Pos), .blockX4Pos(blockX4Pos),
    .blockY1Pos(blockY1Pos), .blockY2Pos(blockY2Pos), .blockY3Pos(blockY3Pos), .blockY4Pos(blockY4Pos),
    .blockColor(blockColor), .pixel_index(pixel_index), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: board contents, current falling piece, clear-in-progress flag
  int board[228];
  int sh_x[4], sh_y[4];
  int sh_c;
  bit in_clear;

  int  exp_q[$], xq[$], yq[$];
  logic stim_vld = 1'b0;
  logic v1 = 1'b0, v2 = 1'b0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic int model_pixel(input int x, input int y, input bit bl);
    int c, r;
    if (in_clear || !bl) return 0;
    if (x < 240 || y < 48) return 0;
    c = (x - 240) / 16;
    r = (y - 48) / 16;
    if (c >= 12 || r >= 19) return 0;
    for (int b = 0; b < 4; b++)
      if (sh_x[b] == c && sh_y[b] == r) return sh_c;
    return board[r * 12 + c];
  endfunction

  always @(posedge Clk) begin
    v1 <= stim_vld;
    v2 <= v1;
  end

  always @(negedge Clk) begin
    if (v2) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got %0d expected none", pixel_index);
      end else begin
        int e, x, y;
        e = exp_q.pop_front();
        x = xq.pop_front();
        y = yq.pop_front();
        checks++;
        if (int'(pixel_index) != e) begin
          errors++;
          $display("FAIL pixel(x=%0d,y=%0d): got %0d expected %0d", x, y, pixel_index, e);
        end
      end
    end
  end

  task automatic put_pixel(input int x, input int y, input bit bl);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = bl;
    exp_q.push_back(model_pixel(x, y, bl));
    xq.push_back(x);
    yq.push_back(y);
    stim_vld = 1'b1;
    @(posedge Clk); #1;
    stim_vld = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic random_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      int x, y;
      bit bl;
      if ($urandom_range(0, 1) == 1) begin
        x = $urandom_range(230, 440);
        y = $urandom_range(40, 360);
      end else begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 1023);
      end
      bl = ($urandom_range(0, 7) != 0);
      put_pixel(x, y, bl);
    end
  endtask

  task automatic scan_board();
    for (int r = 0; r < 19; r++)
      for (int c = 0; c < 12; c++)
        put_pixel(240 + 16 * c + $urandom_range(0, 15), 48 + 16 * r + $urandom_range(0, 15), 1'b1);
    drain();
  endtask

  task automatic do_reset(input int hold);
    Reset = 1'b1;
    frame_start = 1'b0;
    repeat (hold) @(posedge Clk);
    @(negedge Clk);
    check("reset_busy", int'(busy), 1);
    check("reset_pixel", int'(pixel_index), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    foreach (board[i]) board[i] = 0;
    for (int b = 0; b < 4; b++) begin
      sh_x[b] = 0;
      sh_y[b] = 0;
    end
    sh_c = 0;
    in_clear = 1'b1;
    fork
      begin
        int n;
        n = 0;
        @(negedge Clk);
        while (busy && n < 400) begin
          n++;
          @(negedge Clk);
        end
        check("clear_busy_cycles", n, 228);
      end
      random_pixels(150);
    join
    in_clear = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic do_frame(input int x1, input int y1, input int x2, input int y2,
                          input int x3, input int y3, input int x4, input int y4,
                          input int color, input bit inject);
    int want_busy, n;
    want_busy = (color != sh_c) ? 4 : 0;
    blockX1Pos = 6'(x1); blockY1Pos = 7'(y1);
    blockX2Pos = 6'(x2); blockY2Pos = 7'(y2);
    blockX3Pos = 6'(x3); blockY3Pos = 7'(y3);
    blockX4Pos = 6'(x4); blockY4Pos = 7'(y4);
    blockColor = 4'(color);
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    if (color != sh_c)
      for (int b = 0; b < 4; b++)
        if (sh_x[b] < 12 && sh_y[b] < 19) board[sh_y[b] * 12 + sh_x[b]] = sh_c;
    sh_x[0] = x1; sh_y[0] = y1;
    sh_x[1] = x2; sh_y[1] = y2;
    sh_x[2] = x3; sh_y[2] = y3;
    sh_x[3] = x4; sh_y[3] = y4;
    sh_c = color;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (inject && i == 2) begin
        blockX1Pos = 6'd0; blockY1Pos = 7'd0;
        blockX2Pos = 6'd1; blockY2Pos = 7'd0;
        blockX3Pos = 6'd2; blockY3Pos = 7'd0;
        blockX4Pos = 6'd3; blockY4Pos = 7'd0;
        blockColor = 4'((color + 7) % 16);
        frame_start = 1'b1;
      end
      if (inject && i == 3) frame_start = 1'b0;
      @(negedge Clk);
      if (busy) n++;
      @(posedge Clk); #1;
    end
    check(inject ? "lock_busy_inject" : "lock_busy", n, want_busy);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    @(posedge Clk); #1;
    do_reset(3);
    scan_board();

    do_frame(5, 0, 5, 1, 6, 1, 6, 2, 1, 1'b0);
    put_pixel(240 + 5 * 16 + 3, 48 + 2, 1'b1);
    put_pixel(100, 100, 1'b1);
    put_pixel(240 + 5 * 16 + 3, 48 + 2, 1'b0);
    put_pixel(239, 60, 1'b1);
    put_pixel(250, 47, 1'b1);
    drain();

    do_frame(0, 10, 1, 10, 2, 10, 3, 10, 2, 1'b0);
    scan_board();
    do_frame(8, 15, 8, 16, 8, 17, 8, 19, 3, 1'b0);
    do_frame(4, 4, 5, 4, 6, 4, 7, 4, 4, 1'b0);
    scan_board();
    do_frame(9, 2, 9, 3, 10, 3, 10, 4, 5, 1'b1);
    scan_board();
    do_frame(1, 1, 1, 2, 1, 3, 1, 4, 5, 1'b0);
    scan_board();

    do_frame(2, 6, 3, 6, 4, 6, 5, 6, 15, 1'b0);
    do_frame(2, 7, 3, 7, 4, 7, 5, 7, 0, 1'b0);
    scan_board();
    do_frame(2, 6, 3, 6, 4, 6, 5, 6, 0, 1'b0);
    do_frame(2, 9, 3, 9, 4, 9, 5, 9, 1, 1'b0);
    scan_board();

    for (int k = 0; k < 12; k++) begin
      int c;
      c = ($urandom_range(0, 3) == 0) ? sh_c : int'($urandom_range(0, 15));
      do_frame($urandom_range(0, 13), $urandom_range(0, 20), $urandom_range(0, 13), $urandom_range(0, 20),
               $urandom_range(0, 13), $urandom_range(0, 20), $urandom_range(0, 13), $urandom_range(0, 20),
               c, 1'b0);
      random_pixels(60);
      drain();
    end
    scan_board();

    blockColor = 4'((sh_c + 1) % 16);
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    @(posedge Clk); #1;
    do_reset(2);
    scan_board();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
